// File: rtl/pulse_stretch.sv
// Per-channel LED pulse stretcher: turns 1-cycle status strobes into NHOLD-cycle LED pulses
// separated by at least NGAP off-cycles, with an optional one-deep event queue.
module pulse_stretch #(
   parameter int NCH    = 4,
   parameter int NHOLD  = 650000,
   parameter int NGAP   = 650000,
   parameter int NBITS  = 20,
   parameter int RETRIG = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCH-1:0]   event_in,
   output logic [NCH-1:0]   led,
   output logic [NCH-1:0]   busy,
   output logic [NCH-1:0]   miss
);

   // state  | meaning
   // S_IDLE | led off, waiting for an event
   // S_ON   | led on, counting the hold time
   // S_GAP  | led off, enforcing the minimum off-time before the next blink
   typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_e;

   localparam logic [NBITS-1:0] HOLD_TC = NBITS'(NHOLD - 1);
   localparam logic [NBITS-1:0] GAP_TC  = NBITS'(NGAP - 1);

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      state_e           state_q, state_d;
      logic [NBITS-1:0] count_q, count_d;
      logic             pending_q, pending_d;
      logic             led_q, led_d;
      logic             busy_q, busy_d;
      logic             miss_q, miss_d;
      logic             do_exit;
      logic             ev;

      assign ev = event_in[g];

      always_comb begin
         state_d   = state_q;
         count_d   = count_q;
         pending_d = pending_q;
         miss_d    = 1'b0;
         do_exit   = 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (ev) begin
                  state_d = S_ON;
                  count_d = '0;
               end
            end
            S_ON: begin
               // Retrigger wins over the terminal count so the hold always
               // extends a full NHOLD past the last event.
               if (ev && (RETRIG != 0)) begin
                  count_d = '0;
               end else begin
                  if (ev) begin
                     if (pending_q) miss_d    = 1'b1;
                     else           pending_d = 1'b1;
                  end
                  if (count_q == HOLD_TC) begin
                     if (NGAP == 0) begin
                        do_exit = 1'b1;
                     end else begin
                        state_d = S_GAP;
                        count_d = '0;
                     end
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (ev) begin
                  if (pending_q) miss_d    = 1'b1;
                  else           pending_d = 1'b1;
               end
               if (count_q == GAP_TC) do_exit = 1'b1;
               else                   count_d = count_q + 1'b1;
            end
            default: begin
               state_d = S_IDLE;
               count_d = '0;
            end
         endcase

         // pending_d already folds in an event sampled on the exit edge.
         if (do_exit) begin
            if (pending_d) begin
               state_d   = S_ON;
               count_d   = '0;
               pending_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end

         led_d  = (state_d == S_ON);
         busy_d = (state_d != S_IDLE) | pending_d;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            pending_q <= 1'b0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            miss_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            miss_q    <= miss_d;
         end
      end

      assign led[g]  = led_q;
      assign busy[g] = busy_q;
      assign miss[g] = miss_q;
   end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: three instances (retrigger, queued, no-gap) driven from per-cycle
// stimulus masks, with expected {led,busy,miss} pushed to a scoreboard and popped after each edge.
module tb_pulse_stretch;

   logic       clk;
   logic       reset;
   logic [1:0] ev_a, ev_b, ev_c;
   logic [1:0] led_a, busy_a, miss_a;
   logic [1:0] led_b, busy_b, miss_b;
   logic [1:0] led_c, busy_c, miss_c;

   pulse_stretch #(.NCH(2), .NHOLD(4), .NGAP(2), .NBITS(3), .RETRIG(1)) u_a (
      .clk(clk), .reset(reset), .event_in(ev_a), .led(led_a), .busy(busy_a), .miss(miss_a));
   pulse_stretch #(.NCH(2), .NHOLD(4), .NGAP(2), .NBITS(3), .RETRIG(0)) u_b (
      .clk(clk), .reset(reset), .event_in(ev_b), .led(led_b), .busy(busy_b), .miss(miss_b));
   pulse_stretch #(.NCH(2), .NHOLD(4), .NGAP(0), .NBITS(3), .RETRIG(1)) u_c (
      .clk(clk), .reset(reset), .event_in(ev_c), .led(led_c), .busy(busy_c), .miss(miss_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [5:0] exp;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [5:0] act, input logic [5:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got led/busy/miss=%b required %b", tag, act, exp);
   endtask

   function automatic logic [5:0] obs(input int sel);
      case (sel)
         0:       return {led_a, busy_a, miss_a};
         1:       return {led_b, busy_b, miss_b};
         default: return {led_c, busy_c, miss_c};
      endcase
   endfunction

   task automatic do_reset(input string name);
      reset = 1'b1;
      ev_a  = 2'b11;
      ev_b  = 2'b11;
      ev_c  = 2'b11;
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) chk($sformatf("%s_rst_dut%0d", name, s), obs(s), 6'b0);
      reset = 1'b0;
      ev_a  = 2'b00;
      ev_b  = 2'b00;
      ev_c  = 2'b00;
   endtask

   // Bit k of every mask refers to edge Ek (stimulus sampled at Ek, outputs seen after Ek).
   task automatic run(input string name, input int sel, input int n,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] rst,
                      input logic [31:0] l0, input logic [31:0] l1,
                      input logic [31:0] b0, input logic [31:0] b1,
                      input logic [31:0] m0, input logic [31:0] m1);
      sb_entry_t e;
      for (int k = 0; k < n; k++) begin
         reset = rst[k];
         case (sel)
            0:       ev_a = {e1[k], e0[k]};
            1:       ev_b = {e1[k], e0[k]};
            default: ev_c = {e1[k], e0[k]};
         endcase
         e.tag = $sformatf("%s_E%0d", name, k);
         e.exp = {l1[k], l0[k], b1[k], b0[k], m1[k], m0[k]};
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         chk(e.tag, obs(sel), e.exp);
      end
      reset = 1'b0;
      ev_a  = 2'b00;
      ev_b  = 2'b00;
      ev_c  = 2'b00;
   endtask

   initial begin
      reset = 1'b1;
      ev_a  = 2'b00;
      ev_b  = 2'b00;
      ev_c  = 2'b00;
      repeat (2) @(posedge clk);
      #1;

      do_reset("init");
      // single pulse: led E0..E3, busy E0..E5
      run("single", 0, 10, 32'h1, 32'h0, 32'h0,
          32'hF, 32'h0, 32'h3F, 32'h0, 32'h0, 32'h0);

      do_reset("r1");
      // retrigger at E2 extends hold to E5, gap E6..E7
      run("retrig", 0, 12, 32'h5, 32'h0, 32'h0,
          32'h3F, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0);

      do_reset("r2");
      // held-high event with retrigger: led stays on until NHOLD after the last event
      run("held", 0, 13, 32'h3F, 32'h0, 32'h0,
          32'h1FF, 32'h0, 32'h7FF, 32'h0, 32'h0, 32'h0);

      do_reset("r3");
      // queued second event: blinks E0..E3 and E6..E9, busy through E11
      run("queue", 1, 14, 32'h5, 32'h0, 32'h0,
          32'h3CF, 32'h0, 32'hFFF, 32'h0, 32'h0, 32'h0);

      do_reset("r4");
      // third event while pending is dropped: miss only at E2, still two blinks
      run("miss", 1, 14, 32'h7, 32'h0, 32'h0,
          32'h3CF, 32'h0, 32'hFFF, 32'h0, 32'h4, 32'h0);

      do_reset("r5");
      // reset at E2 (with an event on that edge) clears pulse and pending; new event at E5
      run("midrst", 1, 13, 32'h27, 32'h0, 32'h4,
          32'h1E3, 32'h0, 32'h7E3, 32'h0, 32'h0, 32'h0);

      do_reset("r6");
      // no gap: channels independent, busy falls with each led
      run("indep", 2, 8, 32'h1, 32'h4, 32'h0,
          32'hF, 32'h3C, 32'hF, 32'h3C, 32'h0, 32'h0);

      do_reset("final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete, got no end required end");
      $fatal(1, "timeout");
   end

endmodule
